avalon_quad_encoder: RTL and testbench

Multi-channel quadrature encoder counter with an Avalon-MM slave interface for the HPS/Nios register bus. Each channel:
- synchronises and glitch-filters its A/B inputs
- decodes them at x4 resolution into a signed counter
- exposes count, direction and error status as readable/writable registers
- drives a parallel count bus for other fabric logic.

---
 rtl/avalon_quad_encoder.sv | 228 ++++++++++++++++++++++
 tb/tb_avalon_quad_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_quad_encoder.sv
// avalon_quad_encoder: multi-channel x4 quadrature encoder counter behind an
// Avalon-MM slave.
//
// Each channel synchronises and glitch-filters its A/B inputs, then decodes
// the filtered pair into a signed CNT_W-bit counter. The channel also keeps a
// direction bit, a sticky error flag and an enable bit.
//
// Optional feature, selected by the macro ENC_INDEX_EN:
//   - adds the enc_z index inputs
//   - a filtered rising Z edge on an enabled channel clears its counter and
//     sets a sticky index flag
//
// Ports:
//   clk, reset      system clock; asynchronous active-high reset
//   address         word address {channel, sel}; sel 0 = COUNT, sel 1 = STATUS
//   read, write     Avalon strobes; reads take exactly one wait state
//   writedata       write data
//   readdata        registered read data, holds between reads
//   waitrequest     read && wait_flag
//   enc_a, enc_b    asynchronous encoder inputs, one bit per channel
//   enc_z           asynchronous index inputs (ENC_INDEX_EN only)
//   count           live counters, channel 0 in the LSBs
module avalon_quad_encoder #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    waitrequest,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
`ifdef ENC_INDEX_EN
  input  logic [NUM_CH-1:0]       enc_z,
`endif
  output logic [NUM_CH*CNT_W-1:0] count
);

  localparam int unsigned CH_W = ADDR_W - 1;
  localparam int unsigned FC_W = 4;
`ifdef ENC_INDEX_EN
  localparam int unsigned NB   = 3;
`else
  localparam int unsigned NB   = 2;
`endif
  localparam int unsigned IN_W = NB * NUM_CH;

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  logic [IN_W-1:0] raw_in, sync1_q, sync2_q, filt;
  logic            sel;
  logic [CH_W-1:0] chan;
  logic [31:0]     rd_val;
  logic [NUM_CH-1:0] en_v, err_v, dir_v, idx_v;
  logic [CNT_W-1:0]  cnt_a [NUM_CH];
  rd_state_t       rd_state_q, rd_state_d;
  logic            rd_capture;
  logic            unused_wd;

  // Gray position of an {A,B} pair along the forward sequence 00,10,11,01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign sel       = address[0];
  assign chan      = address[ADDR_W-1:1];
  assign unused_wd = ^writedata;

`ifdef ENC_INDEX_EN
  assign raw_in = {enc_z, enc_b, enc_a};
`else
  assign raw_in = {enc_b, enc_a};
`endif

  // Two-flop synchroniser for every asynchronous encoder bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Stability filter: the output follows only after FILT_LEN consecutive
  // samples that all differ from the current filtered value.
  for (genvar j = 0; j < IN_W; j++) begin : g_filt
    logic [FC_W-1:0] stab_q;
    logic            filt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stab_q <= '0;
        filt_q <= 1'b0;
      end else if (sync2_q[j] == filt_q) begin
        stab_q <= '0;
      end else if (stab_q == FC_W'(FILT_LEN - 1)) begin
        filt_q <= sync2_q[j];
        stab_q <= '0;
      end else begin
        stab_q <= stab_q + FC_W'(1);
      end
    end
    assign filt[j] = filt_q;
  end

  // Per-channel decoder, counter and status.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       ab, last_ab_q, delta;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q, err_q, dir_q, idx_q;
    logic             hit, wr_cnt, wr_st;
    logic             step_up, step_dn, illegal, idx_rise;

    assign ab      = {filt[i], filt[NUM_CH+i]};
    assign delta   = gray_pos(ab) - gray_pos(last_ab_q);
    assign hit     = write && (chan == CH_W'(i));
    assign wr_cnt  = hit && !sel;
    assign wr_st   = hit && sel;
    assign step_up = en_q && (delta == 2'd1);
    assign step_dn = en_q && (delta == 2'd3);
    assign illegal = en_q && (delta == 2'd2);

    // Priority: preset write, then index clear, then decode step.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q     <= '0;
        dir_q     <= 1'b1;
        en_q      <= 1'b1;
        err_q     <= 1'b0;
        last_ab_q <= 2'b00;
      end else begin
        last_ab_q <= ab;
        if (wr_cnt) begin
          cnt_q <= writedata[CNT_W-1:0];
        end else if (idx_rise) begin
          cnt_q <= '0;
        end else if (step_up) begin
          cnt_q <= cnt_q + CNT_W'(1);
          dir_q <= 1'b1;
        end else if (step_dn) begin
          cnt_q <= cnt_q - CNT_W'(1);
          dir_q <= 1'b0;
        end
        if (wr_st) en_q <= writedata[0];
        // A new illegal transition outranks a same-cycle clear.
        if (illegal) begin
          err_q <= 1'b1;
        end else if (wr_st && writedata[1]) begin
          err_q <= 1'b0;
        end
      end
    end

`ifdef ENC_INDEX_EN
    logic z_prev_q;
    assign idx_rise = en_q && filt[2*NUM_CH+i] && !z_prev_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        z_prev_q <= 1'b0;
        idx_q    <= 1'b0;
      end else begin
        z_prev_q <= filt[2*NUM_CH+i];
        if (idx_rise) begin
          idx_q <= 1'b1;
        end else if (wr_st && writedata[3]) begin
          idx_q <= 1'b0;
        end
      end
    end
`else
    assign idx_rise = 1'b0;
    assign idx_q    = 1'b0;
`endif

    assign en_v[i]  = en_q;
    assign err_v[i] = err_q;
    assign dir_v[i] = dir_q;
    assign idx_v[i] = idx_q;
    assign cnt_a[i] = cnt_q;
    assign count[i*CNT_W +: CNT_W] = cnt_q;
  end

  // Register read mux; unmapped channels read as zero.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (chan == CH_W'(i)) begin
        if (sel) rd_val = {28'd0, idx_v[i], dir_v[i], err_v[i], en_v[i]};
        else     rd_val = 32'($signed(cnt_a[i]));
      end
    end
  end

  // Read handshake: RD_IDLE is the wait_flag=1 state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_state_q <= RD_IDLE;
    else       rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = RD_IDLE;
    rd_capture = 1'b0;
    if (read && (rd_state_q == RD_IDLE)) begin
      rd_state_d = RD_DATA;
      rd_capture = 1'b1;
    end
  end

  assign waitrequest = read && (rd_state_q == RD_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           readdata <= '0;
    else if (rd_capture) readdata <= rd_val;
  end

endmodule

// File: tb/tb_avalon_quad_encoder.sv
// Self-checking bench for avalon_quad_encoder.
//
// The reference model tracks each channel as an integer position on the
// encoder wheel. It derives the A/B levels from that position, and applies
// count, direction and error effects from the intended motion.
module tb_avalon_quad_encoder;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 32;
  localparam int FILT_LEN = 3;
  localparam int ADDR_W   = 5;
  localparam int SETTLE   = FILT_LEN + 6;

  logic                    clk;
  logic                    reset;
  logic [ADDR_W-1:0]       address;
  logic                    read, write;
  logic [31:0]             writedata, readdata;
  logic                    waitrequest;
  logic [NUM_CH-1:0]       enc_a, enc_b;
`ifdef ENC_INDEX_EN
  logic [NUM_CH-1:0]       enc_z;
`endif
  logic [NUM_CH*CNT_W-1:0] count;

  avalon_quad_encoder #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .enc_a(enc_a), .enc_b(enc_b),
`ifdef ENC_INDEX_EN
    .enc_z(enc_z),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          m_pos [NUM_CH];
  logic [31:0] m_cnt [NUM_CH];
  bit          m_en [NUM_CH], m_err [NUM_CH], m_dir [NUM_CH], m_idx [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0; m_cnt[c] = '0; m_en[c] = 1; m_err[c] = 0; m_dir[c] = 1; m_idx[c] = 0;
    end
  endtask

  task automatic do_reset();
    enc_a = '0; enc_b = '0;
`ifdef ENC_INDEX_EN
    enc_z = '0;
`endif
    read = 0; write = 0; address = '0; writedata = '0;
    reset = 1;
    repeat (4) @(negedge clk);
    chk("rst_readdata", readdata, 32'h0);
    reset = 0;
    model_reset();
  endtask

  task automatic bus_write(input int ch, input bit sel, input logic [31:0] data);
    @(negedge clk);
    address = {4'(ch), sel}; writedata = data; write = 1;
    @(negedge clk);
    write = 0;
  endtask

  task automatic bus_read(input int ch, input bit sel, output logic [31:0] data);
    @(negedge clk);
    address = {4'(ch), sel}; read = 1;
    #1 chk("wait_hi", {31'd0, waitrequest}, 32'd1);
    @(negedge clk);
    chk("wait_lo", {31'd0, waitrequest}, 32'd0);
    data = readdata;
    @(posedge clk);
    #1 read = 0;
  endtask

  task automatic wr_count(input int ch, input logic [31:0] v);
    bus_write(ch, 0, v);
    if (ch < NUM_CH) m_cnt[ch] = v;
  endtask

  task automatic wr_status(input int ch, input logic [31:0] v);
    bus_write(ch, 1, v);
    if (ch < NUM_CH) begin
      m_en[ch] = v[0];
      if (v[1]) m_err[ch] = 0;
`ifdef ENC_INDEX_EN
      if (v[3]) m_idx[ch] = 0;
`endif
    end
  endtask

  // Rotate the wheel by k positions (+1, -1, or 2 for an illegal jump).
  task automatic move(input int ch, input int k, input bit settle);
    logic [1:0] ab;
    @(negedge clk);
    m_pos[ch] = (m_pos[ch] + k) & 3;
    ab = seq[m_pos[ch]];
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
    if (m_en[ch]) begin
      if (k == 1)       begin m_cnt[ch] = m_cnt[ch] + 1; m_dir[ch] = 1; end
      else if (k == -1) begin m_cnt[ch] = m_cnt[ch] - 1; m_dir[ch] = 0; end
      else              m_err[ch] = 1;
    end
    if (settle) repeat (SETTLE) @(negedge clk);
  endtask

  task automatic check_ch(input int ch);
    logic [31:0] d;
    bus_read(ch, 0, d);
    chk($sformatf("count_reg%0d", ch), d, m_cnt[ch]);
    bus_read(ch, 1, d);
    chk($sformatf("status%0d", ch), d,
        {28'd0, m_idx[ch], m_dir[ch], m_err[ch], m_en[ch]});
    chk($sformatf("count_bus%0d", ch), count[ch*CNT_W +: CNT_W], m_cnt[ch]);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, old;
    bit          sdir;
    int          ch, op;

    do_reset();
    bus_read(0, 0, d);
    chk("reset_count0", d, 32'h0);
    for (int c = 0; c < NUM_CH; c++) check_ch(c);

    for (int s = 0; s < 8; s++) move(1, 1, 1);
    bus_read(1, 0, d); chk("fwd8", d, 32'd8);
    check_ch(1);
    for (int s = 0; s < 3; s++) move(1, -1, 1);
    bus_read(1, 0, d); chk("rev3", d, 32'd5);
    check_ch(1);

    wr_count(0, 32'h7FFF_FFFF);
    move(0, 1, 1);
    bus_read(0, 0, d); chk("wrap_max", d, 32'h8000_0000);
    wr_count(0, 32'h0);
    move(0, -1, 1);
    bus_read(0, 0, d); chk("wrap_min", d, 32'hFFFF_FFFF);
    check_ch(0);

    move(2, 2, 1);
    check_ch(2);
    wr_status(2, 32'h3);
    check_ch(2);

    @(negedge clk) enc_a[3] = ~enc_a[3];
    @(negedge clk);
    @(negedge clk) enc_a[3] = ~enc_a[3];
    repeat (SETTLE) @(negedge clk);
    check_ch(3);

    wr_status(3, 32'h0);
    for (int s = 0; s < 4; s++) move(3, 1, 1);
    wr_status(3, 32'h1);
    move(3, 1, 1);
    bus_read(3, 0, d); chk("reenable", d, 32'd1);
    check_ch(3);

    // Input-to-count latency: counter changes on the sixth edge.
    old = m_cnt[1];
    move(1, 1, 0);
    repeat (5) @(negedge clk);
    chk("lat_before", count[1*CNT_W +: CNT_W], old);
    @(negedge clk);
    chk("lat_after", count[1*CNT_W +: CNT_W], m_cnt[1]);
    repeat (SETTLE) @(negedge clk);

    // Preset write coinciding with a decode step: write wins, step dropped.
    move(1, -1, 1);
    sdir = m_dir[1];
    move(1, 1, 0);
    repeat (4) @(negedge clk);
    bus_write(1, 0, 32'h0000_1234);
    m_cnt[1] = 32'h0000_1234;
    m_dir[1] = sdir;
    repeat (SETTLE) @(negedge clk);
    check_ch(1);

    // Error clear coinciding with a new illegal transition: flag stays set.
    move(2, 2, 0);
    repeat (4) @(negedge clk);
    bus_write(2, 1, 32'h3);
    repeat (SETTLE) @(negedge clk);
    check_ch(2);
    wr_status(2, 32'h3);
    check_ch(2);

    bus_read(9, 0, d);  chk("oor_count", d, 32'h0);
    bus_read(15, 1, d); chk("oor_status", d, 32'h0);
    bus_write(5, 0, 32'hDEAD_BEEF);
    bus_write(6, 1, 32'h0);
    for (int c = 0; c < NUM_CH; c++) check_ch(c);

`ifdef ENC_INDEX_EN
    wr_count(0, 32'd100);
    @(negedge clk) enc_z[0] = 1;
    repeat (SETTLE) @(negedge clk);
    m_cnt[0] = 0; m_idx[0] = 1;
    bus_read(0, 0, d); chk("index_clear", d, 32'h0);
    check_ch(0);
    wr_status(0, 32'h9);
    @(negedge clk) enc_z[0] = 0;
    repeat (SETTLE) @(negedge clk);
    @(negedge clk) enc_z[0] = 1;
    repeat (4) @(negedge clk);
    bus_write(0, 0, 32'd42);
    m_cnt[0] = 32'd42; m_idx[0] = 1;
    repeat (SETTLE) @(negedge clk);
    bus_read(0, 0, d); chk("index_vs_write", d, 32'd42);
    check_ch(0);
    wr_status(0, 32'h9);
    check_ch(0);
`endif

    for (int it = 0; it < 150; it++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: move(ch, 1, 1);
        3, 4, 5: move(ch, -1, 1);
        6:       move(ch, 2, 1);
        7:       wr_count(ch, $urandom());
        8:       wr_status(ch, {30'd0, 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 3) != 0)});
        default: check_ch(ch);
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) check_ch(c);

    // Reset during the data cycle of a read abandons it immediately.
    @(negedge clk);
    address = '0; read = 1;
    @(negedge clk);
    chk("midread_wait", {31'd0, waitrequest}, 32'd0);
    reset = 1;
    #1 chk("midread_rst_wait", {31'd0, waitrequest}, 32'd1);
    chk("midread_rst_data", readdata, 32'h0);
    @(negedge clk);
    read = 0;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) check_ch(c);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
